systolic_mm_core: RTL
=====================

# systolic_mm_core

Parametrised systolic matrix-multiply core: the successor to the fixed 8/10-column PE grid. It computes a ROWS×COLS output tile P = A·B over a runtime reduction depth K. Input skewing, PE clear/accumulate control and a backpressured row-by-row result drain are all internal. It sits between the buffer-fetch controller, which streams one A column and one B row per beat, and the P write-back path.

## Interface
- ROWS, 8, PE rows; number of A elements per beat; number of output rows.
- COLS, 8, PE columns; number of B elements per beat; elements per output row.
- DATA_W, 8, signed operand width.
- ACC_W, 32, signed accumulator width; must satisfy ACC_W ≥ 2·DATA_W.
- K_W, 16, width of k_i.
- clk_i  in  1  sole clock; all logic on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  starts a tile; sampled only in IDLE.
- acc_i  in  1  sampled with start_i; 1 keeps prior accumulator contents, 0 clears them.
- k_i  in  K_W  reduction depth (beats); sampled with start_i.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the tile completes.
- in_valid_i  in  1  operand beat valid.
- in_ready_o  out  1  high only in LOAD.
- a_word_i  in  ROWS·DATA_W  A column k; element r at [r·DATA_W +: DATA_W].
- b_word_i  in  COLS·DATA_W  B row k; element c at [c·DATA_W +: DATA_W].
- out_valid_o  out  1  result row valid.
- out_ready_i  in  1  consumer accepts the row.
- out_row_o  out  max(1,$clog2(ROWS))  index of the presented row.
- out_word_o  out  COLS·ACC_W  P[out_row_o][c] at [c·ACC_W +: ACC_W].

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: start_i=1 latches k_i and acc_i. If acc_i=0, all PE accumulators are cleared in the same edge.
  - k_i≠0 → LOAD.
  - k_i=0 → DRAIN directly. Rows then read zero, or the previous contents if acc_i=1.
- LOAD: a beat is accepted when in_valid_i && in_ready_o. The beat counter increments per accepted beat. The state moves to FLUSH on the edge that accepts beat k−1.
- Bubbles: a cycle with in_valid_i=0 in LOAD injects zero operands into the skew stage. Results are identical to a bubble-free stream.
- Skew: A element r is delayed r cycles; B element c is delayed c cycles.
- PE grid: A operands shift right along a row; B operands shift down a column. PE(r,c) performs acc += A·B every cycle: signed DATA_W×DATA_W product, sign-extended to ACC_W, with two's-complement wrap (no saturation).
- FLUSH: fixed ROWS+COLS−1 cycles, counted from the cycle after the last accepted beat. Zeros are injected. The state then moves to DRAIN.
- DRAIN: rows are presented in order 0..ROWS−1. out_word_o is the registered accumulators of that row.
  - The row advances only on out_valid_o && out_ready_i.
  - The handshake on row ROWS−1 moves the state to IDLE and pulses done_o.
- Accumulators hold their value after DRAIN. This allows acc_i=1 K-splitting across tiles.
- start_i outside IDLE is ignored. in_valid_i outside LOAD is ignored.

## Timing
- Reset values: busy_o=0, done_o=0, in_ready_o=0, out_valid_o=0, out_row_o=0, out_word_o=0. State=IDLE. All accumulators, skew registers and counters are 0.
- Start: start_i at edge t → busy_o=1 and in_ready_o=1 from t+1 (k≠0).
- First DRAIN cycle: K accepted beats (no bubbles) + ROWS+COLS−1 FLUSH cycles after the LOAD entry. out_valid_o=1 in that first DRAIN cycle.
- Drain throughput: one row per cycle with out_ready_i held high.
- Backpressure: while out_valid_o && !out_ready_i, out_row_o and out_word_o are held stable.
- Completion: done_o is high for exactly the cycle after the final row handshake. busy_o=0 in that same cycle, and a new start_i is accepted in that cycle.
- Reset mid-operation: rst_i in any state returns all outputs and registers to reset values on that edge. No done_o is produced.

## Test plan
- Identity (ROWS=COLS=4, K=4): A=I, B rows = {1,2,3,4},{5..8},{9..12},{13..16} → rows 0..3 equal the B rows; done_o one cycle after the row-3 handshake.
- Signed extremes (K=1):
  - A all −128, B all −128 → every element 16384.
  - A all −1, B all 127 → every element −127.
- Bubbles: identity test with in_valid_i low on alternate cycles → identical results. in_ready_o stays high through LOAD.
- Accumulate: identity run, then start with acc_i=1 and the same data → every element equals 2× its B value.
- Backpressure: out_ready_i low for 3 cycles while row 1 is presented → out_row_o=1 and data stable; rows 0..3 each seen exactly once.
- Corner cases:
  - k_i=0 with acc_i=0 → four zero rows, then done_o.
  - rst_i asserted mid-LOAD → busy_o=0 next cycle; a following identity run is correct.

Source files
------------

// File: rtl/systolic_mm_core.sv
// systolic_mm_core: ROWS x COLS output-stationary systolic matrix multiply.
// Computes P = A*B over a runtime depth K. One A column and one B row arrive
// per beat; operands are skewed internally, accumulated in the PE grid, then
// drained one row per handshake.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, acc_i, k_i          tile start (IDLE only), keep-accumulators, depth
//   busy_o, done_o               not-IDLE flag, one-cycle completion pulse
//   in_valid_i/in_ready_o        operand beat handshake (ready only in LOAD)
//   a_word_i, b_word_i           A column / B row, element i at [i*DATA_W +: DATA_W]
//   out_valid_o/out_ready_i      result row handshake
//   out_row_o, out_word_o        presented row index and its ACC_W-wide elements
module systolic_mm_core #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned K_W    = 16,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    acc_i,
    input  logic [K_W-1:0]          k_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [ROWS*DATA_W-1:0]  a_word_i,
    input  logic [COLS*DATA_W-1:0]  b_word_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [ROW_W-1:0]        out_row_o,
    output logic [COLS*ACC_W-1:0]   out_word_o
);

    localparam int unsigned PROD_W     = 2 * DATA_W;
    localparam int unsigned FL_W       = $clog2(ROWS + COLS);
    localparam int unsigned FLUSH_LAST = ROWS + COLS - 2;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [K_W-1:0]    cnt_q, cnt_d;
    logic [FL_W-1:0]   fcnt_q, fcnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              busy_q, ready_q, valid_q, done_q, done_d;
    logic              clr_acc;
    logic              accept;

    // Signed product sign-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'($signed(a)) * PROD_W'($signed(b));
        return ACC_W'(p);
    endfunction

    assign accept = in_valid_i & ready_q;

    // Next-state and control.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        row_d   = row_q;
        done_d  = 1'b0;
        clr_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    k_d     = k_i;
                    cnt_d   = '0;
                    fcnt_d  = '0;
                    row_d   = '0;
                    clr_acc = ~acc_i;
                    state_d = (k_i == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + K_W'(1);
                    if (cnt_q == k_q - K_W'(1)) begin
                        state_d = FLUSH;
                        fcnt_d  = '0;
                    end
                end
            end
            FLUSH: begin
                if (fcnt_q == FL_W'(FLUSH_LAST)) begin
                    state_d = DRAIN;
                    row_d   = '0;
                end else begin
                    fcnt_d = fcnt_q + FL_W'(1);
                end
            end
            DRAIN: begin
                if (valid_q && out_ready_i) begin
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            row_q   <= row_d;
            busy_q  <= (state_d != IDLE);
            ready_q <= (state_d == LOAD);
            valid_q <= (state_d == DRAIN);
            done_q  <= done_d;
        end
    end

    // Unaccepted cycles feed zeros, so bubbles and flush contribute nothing.
    logic [ROWS*DATA_W-1:0] a_in, a_skw;
    logic [COLS*DATA_W-1:0] b_in, b_skw;
    assign a_in = accept ? a_word_i : '0;
    assign b_in = accept ? b_word_i : '0;

    // A element r delayed r cycles.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_pass
            assign a_skw[DATA_W-1:0] = a_in[DATA_W-1:0];
        end else begin : g_dly
            logic [DATA_W-1:0] sr [r];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= a_in[r*DATA_W +: DATA_W];
                    for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
                end
            end
            assign a_skw[r*DATA_W +: DATA_W] = sr[r-1];
        end
    end

    // B element c delayed c cycles.
    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_pass
            assign b_skw[DATA_W-1:0] = b_in[DATA_W-1:0];
        end else begin : g_dly
            logic [DATA_W-1:0] sr [c];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < c; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= b_in[c*DATA_W +: DATA_W];
                    for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
                end
            end
            assign b_skw[c*DATA_W +: DATA_W] = sr[c-1];
        end
    end

    // PE grid: A moves right, B moves down, every PE accumulates each cycle.
    logic [DATA_W-1:0] a_pe  [ROWS][COLS];
    logic [DATA_W-1:0] b_pe  [ROWS][COLS];
    logic [ACC_W-1:0]  acc_q [ROWS][COLS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_pe[r][c]  <= '0;
                    b_pe[r][c]  <= '0;
                    acc_q[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                a_pe[r][0] <= a_skw[r*DATA_W +: DATA_W];
                for (int c = 1; c < COLS; c++) a_pe[r][c] <= a_pe[r][c-1];
            end
            for (int c = 0; c < COLS; c++) begin
                b_pe[0][c] <= b_skw[c*DATA_W +: DATA_W];
                for (int r = 1; r < ROWS; r++) b_pe[r][c] <= b_pe[r-1][c];
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    acc_q[r][c] <= clr_acc ? '0
                                 : acc_q[r][c] + mac_term(a_pe[r][c], b_pe[r][c]);
                end
            end
        end
    end

    // Selected row of accumulator registers; row index only moves on handshake.
    always_comb begin
        out_word_o = '0;
        for (int c = 0; c < COLS; c++) begin
            out_word_o[c*ACC_W +: ACC_W] = acc_q[row_q][c];
        end
    end

    assign busy_o      = busy_q;
    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign done_o      = done_q;
    assign out_row_o   = row_q;

endmodule
